// File: rtl/instr_sequencer.sv
// Program sequencer feeding a cpu: fetches 16-bit words from a small program
// memory and hands each one over with load/start strobes and a w handshake.
module instr_sequencer #(
    parameter int unsigned ADDR_W      = 5,
    parameter logic [15:0] HALT_INSTR  = 16'hE000,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              cpu_w,
    output logic [15:0]       cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_ACK,
        S_EXEC,
        S_HALT
    } state_t;

    localparam int unsigned       CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    state_t            state_q, state_d;
    logic [15:0]       mem_q [0:(1<<ADDR_W)-1];
    logic [15:0]       rdata_q;
    logic [15:0]       cpu_in_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]  ack_q, ack_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic              load_fire;

    // Memory keeps its contents through reset; the read port only samples in FETCH.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem_q[prog_addr] <= prog_data;
        end
        if (state_q == S_FETCH) begin
            rdata_q <= mem_q[pc_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        halted_d  = halted_q;
        error_d   = error_q;
        load_fire = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (run) begin
                    pc_d     = '0;
                    cnt_d    = '0;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (rdata_q == HALT_INSTR) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (cpu_w) begin
                    load_fire = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                ack_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (!cpu_w) begin
                    state_d = S_EXEC;
                end else if (ack_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    ack_d = ack_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (cpu_w) begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (pc_q == PC_LAST) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            cpu_in_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            if (load_fire) begin
                cpu_in_q <= rdata_q;
            end
        end
    end

    // The word is presented in the same cycle as its load strobe, then held.
    assign cpu_in      = load_fire ? rdata_q : cpu_in_q;
    assign cpu_load    = load_fire;
    assign cpu_s       = (state_q == S_START);
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign error       = error_q;
    assign instr_count = cnt_q;

endmodule
